// File: rtl/inertial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inertial_pkg
// Description : Sequencer state encoding and sensor SPI command words.
// Revision    : 1.0 - initial release
// ============================================================================
package inertial_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT = 4'd0,
        CFG0     = 4'd1,
        CFG1     = 4'd2,
        CFG2     = 4'd3,
        CFG3     = 4'd4,
        WAIT_INT = 4'd5,
        RD_PL    = 4'd6,
        RD_PH    = 4'd7,
        RD_AL    = 4'd8,
        RD_AH    = 4'd9,
        VALID    = 4'd10
    } state_t;

    localparam logic [15:0] CMD_INT_CFG = 16'h0D02;
    localparam logic [15:0] CMD_ACC_CFG = 16'h1053;
    localparam logic [15:0] CMD_GYR_CFG = 16'h1150;
    localparam logic [15:0] CMD_RND_CFG = 16'h1460;
    localparam logic [15:0] CMD_PTCH_L  = 16'hA200;
    localparam logic [15:0] CMD_PTCH_H  = 16'hA300;
    localparam logic [15:0] CMD_AZ_L    = 16'hAC00;
    localparam logic [15:0] CMD_AZ_H    = 16'hAD00;

endpackage
`default_nettype wire

// File: rtl/inertial_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : inertial_sequencer_if
// Description : SPI-master, interrupt and integrator signals of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface inertial_sequencer_if;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    modport master (
        input  INT, done, rd_data,
        output wrt, cmd, vld, ptch_rt, AZ
    );

    modport slave (
        output INT, done, rd_data,
        input  wrt, cmd, vld, ptch_rt, AZ
    );
endinterface
`default_nettype wire

// File: rtl/inertial_sequencer_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Generic two-flop synchronizer with synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule
`default_nettype wire

// File: rtl/inertial_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : inertial_sequencer
// Description : Configures the inertial sensor, then reads pitch rate and AZ
//               on every data-ready interrupt. Revision: 1.0 - initial release
// ============================================================================
module inertial_sequencer
    import inertial_pkg::*;
#(
    parameter logic [15:0] INIT_CYCLES = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    inertial_sequencer_if.master bus
);
    state_t      state, nxt_state;
    logic [15:0] timer;
    logic        int_s;
    logic        done_ok;
    logic        wrt_q, vld_q;
    logic [15:0] cmd_q, ptch_q, az_q;
    logic        nxt_wrt, nxt_vld;
    logic [15:0] nxt_cmd;
    logic        cap_pl, cap_ph, cap_al, cap_ah;
    logic        unused_hi;

    sync2 #(.WIDTH(1)) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.INT),
        .q   (int_s)
    );

    // A done coincident with our own wrt cannot complete that transaction.
    assign done_ok   = bus.done & ~wrt_q;
    assign unused_hi = ^bus.rd_data[15:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PWR_WAIT;
            timer  <= 16'h0000;
            wrt_q  <= 1'b0;
            vld_q  <= 1'b0;
            cmd_q  <= 16'h0000;
            ptch_q <= 16'h0000;
            az_q   <= 16'h0000;
        end else begin
            state <= nxt_state;
            wrt_q <= nxt_wrt;
            vld_q <= nxt_vld;
            if (nxt_wrt)            cmd_q        <= nxt_cmd;
            if (state == PWR_WAIT)  timer        <= timer + 16'd1;
            if (cap_pl)             ptch_q[7:0]  <= bus.rd_data[7:0];
            if (cap_ph)             ptch_q[15:8] <= bus.rd_data[7:0];
            if (cap_al)             az_q[7:0]    <= bus.rd_data[7:0];
            if (cap_ah)             az_q[15:8]   <= bus.rd_data[7:0];
        end
    end

    always_comb begin
        nxt_state = state;
        case (state)
            PWR_WAIT: if (timer == INIT_CYCLES - 16'd1) nxt_state = CFG0;
            CFG0:     if (done_ok) nxt_state = CFG1;
            CFG1:     if (done_ok) nxt_state = CFG2;
            CFG2:     if (done_ok) nxt_state = CFG3;
            CFG3:     if (done_ok) nxt_state = WAIT_INT;
            WAIT_INT: if (int_s)   nxt_state = RD_PL;
            RD_PL:    if (done_ok) nxt_state = RD_PH;
            RD_PH:    if (done_ok) nxt_state = RD_AL;
            RD_AL:    if (done_ok) nxt_state = RD_AH;
            RD_AH:    if (done_ok) nxt_state = VALID;
            VALID:    nxt_state = WAIT_INT;
            default:  nxt_state = PWR_WAIT;
        endcase
    end

    always_comb begin
        nxt_wrt = 1'b0;
        nxt_vld = 1'b0;
        nxt_cmd = cmd_q;
        cap_pl  = 1'b0;
        cap_ph  = 1'b0;
        cap_al  = 1'b0;
        cap_ah  = 1'b0;
        case (state)
            PWR_WAIT: if (timer == INIT_CYCLES - 16'd1) begin
                nxt_wrt = 1'b1; nxt_cmd = CMD_INT_CFG;
            end
            CFG0: if (done_ok) begin nxt_wrt = 1'b1; nxt_cmd = CMD_ACC_CFG; end
            CFG1: if (done_ok) begin nxt_wrt = 1'b1; nxt_cmd = CMD_GYR_CFG; end
            CFG2: if (done_ok) begin nxt_wrt = 1'b1; nxt_cmd = CMD_RND_CFG; end
            WAIT_INT: if (int_s) begin nxt_wrt = 1'b1; nxt_cmd = CMD_PTCH_L; end
            RD_PL: if (done_ok) begin
                cap_pl = 1'b1; nxt_wrt = 1'b1; nxt_cmd = CMD_PTCH_H;
            end
            RD_PH: if (done_ok) begin
                cap_ph = 1'b1; nxt_wrt = 1'b1; nxt_cmd = CMD_AZ_L;
            end
            RD_AL: if (done_ok) begin
                cap_al = 1'b1; nxt_wrt = 1'b1; nxt_cmd = CMD_AZ_H;
            end
            RD_AH: if (done_ok) begin
                cap_ah = 1'b1; nxt_vld = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.wrt     = wrt_q;
    assign bus.cmd     = cmd_q;
    assign bus.vld     = vld_q;
    assign bus.ptch_rt = ptch_q;
    assign bus.AZ      = az_q;
endmodule
`default_nettype wire

// File: tb/tb_inertial_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_inertial_sequencer
// Description : Scoreboard bench with a sensor/SPI responder model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_inertial_sequencer;
    import inertial_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_done = 1'b0;
    logic        spur_done = 1'b0;
    logic [15:0] s_data = 16'h0000;

    always #5 clk = ~clk;

    inertial_sequencer_if bus();
    assign bus.done    = s_done | spur_done;
    assign bus.rd_data = s_data;

    inertial_sequencer #(.INIT_CYCLES(16'h0010)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass = 0, n_total = 0;
    int cyc = 0, last_done_cyc = -100;
    int wrt_cnt = 0, vld_cnt = 0, reads = 0;
    int dly_min = 8, dly_max = 8;
    logic wrt_prev = 1'b0, vld_prev = 1'b0;

    logic [15:0] exp_cmd[$];
    logic [31:0] exp_data[$];
    logic [31:0] samples[$];   // {ptch_rt, AZ} the sensor will report next

    task automatic fail_now(input string n);
        n_total++;
        $display("FAIL %s: expected event did not occur (t=%0t)", n, $time);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", n, act, exp, $time);
    endtask

    task automatic push_cfg();
        exp_cmd.push_back(16'h0D02); exp_cmd.push_back(16'h1053);
        exp_cmd.push_back(16'h1150); exp_cmd.push_back(16'h1460);
    endtask

    task automatic push_seq(input logic [31:0] s, input bit expect_vld);
        samples.push_back(s);
        exp_cmd.push_back(16'hA200); exp_cmd.push_back(16'hA300);
        exp_cmd.push_back(16'hAC00); exp_cmd.push_back(16'hAD00);
        if (expect_vld) exp_data.push_back(s);
    endtask

    task automatic wait_wrt(input int target, input int budget, input string n);
        int k = 0;
        while (wrt_cnt < target && k < budget) begin @(negedge clk); k++; end
        if (wrt_cnt < target) fail_now(n);
    endtask

    task automatic wait_vld(input int target, input int budget, input string n);
        int k = 0;
        while (vld_cnt < target && k < budget) begin @(negedge clk); k++; end
        if (vld_cnt < target) fail_now(n);
    endtask

    // Counts rising edges from the call until wrt is seen; a done pulse can be injected on the way.
    task automatic measure_wrt(output int lat, input int spur_at);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            spur_done = (lat == spur_at);
            if (bus.wrt) break;
        end
        spur_done = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SPI master + sensor responder
    initial begin
        logic [15:0] c;
        logic [31:0] cur = 32'h0;
        int d;
        forever begin
            if (bus.wrt === 1'b1) begin
                c = bus.cmd;
                d = $urandom_range(dly_max, dly_min);
                repeat (d - 1) begin @(posedge clk); #1; end
                s_data[15:8] = 8'($urandom);
                case (c)
                    16'hA200: begin
                        cur = (samples.size() > 0) ? samples.pop_front() : $urandom;
                        s_data[7:0] = cur[23:16];
                    end
                    16'hA300: s_data[7:0] = cur[31:24];
                    16'hAC00: s_data[7:0] = cur[7:0];
                    16'hAD00: s_data[7:0] = cur[15:8];
                    default:  s_data[7:0] = 8'($urandom);
                endcase
                s_done = 1'b1;
                @(posedge clk); #1;
                s_done = 1'b0;
                s_data = 16'($urandom);
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done) last_done_cyc = cyc;
            if (bus.wrt) begin
                wrt_cnt++;
                chk("wrt_adjacent", {31'd0, wrt_prev}, 32'd0);
                if (bus.cmd == CMD_PTCH_L) reads = 0;
                reads++;
                if (exp_cmd.size() == 0) fail_now("cmd_unexpected");
                else chk("cmd", {16'd0, bus.cmd}, {16'd0, exp_cmd.pop_front()});
            end
            if (bus.vld) begin
                vld_cnt++;
                chk("vld_width", {31'd0, vld_prev}, 32'd0);
                chk("vld_latency", cyc - last_done_cyc, 32'd1);
                chk("reads_per_vld", reads, 32'd4);
                if (exp_data.size() == 0) fail_now("vld_unexpected");
                else chk("sample", {bus.ptch_rt, bus.AZ}, exp_data.pop_front());
            end
            wrt_prev = bus.wrt;
            vld_prev = bus.vld;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bw, bv;
        logic [31:0] s;
        bus.INT = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_wrt",  {31'd0, bus.wrt}, 32'd0);
        chk("rst_vld",  {31'd0, bus.vld}, 32'd0);
        chk("rst_cmd",  {16'd0, bus.cmd}, 32'd0);
        chk("rst_ptch", {16'd0, bus.ptch_rt}, 32'd0);
        chk("rst_az",   {16'd0, bus.AZ}, 32'd0);

        // power-up delay, with a stray done during PWR_WAIT
        push_cfg();
        rst = 1'b0;
        measure_wrt(lat, 5);
        chk("pwrup_latency", lat, 32'd16);
        wait_wrt(4, 200, "cfg_writes");
        repeat (12) @(negedge clk);
        chk("cfg_wrt_count", wrt_cnt, 32'd4);

        // stray done in WAIT_INT
        spur_done = 1'b1; @(negedge clk); spur_done = 1'b0;
        repeat (6) @(negedge clk);
        chk("spur_wait_wrt", wrt_cnt, 32'd4);
        chk("spur_wait_ptch", {16'd0, bus.ptch_rt}, 32'd0);
        chk("spur_wait_vld", vld_cnt, 32'd0);

        // directed read: ptch 1234, AZ FFF0
        push_seq(32'h1234FFF0, 1'b1);
        bus.INT = 1'b1;
        measure_wrt(lat, 0);
        chk("int_latency", lat, 32'd3);
        @(negedge clk); bus.INT = 1'b0;
        wait_vld(1, 200, "vld_directed");
        @(negedge clk);
        chk("ptch_directed", {16'd0, bus.ptch_rt}, 32'h1234);
        chk("az_directed",   {16'd0, bus.AZ}, 32'hFFF0);

        // randomized single sequences
        dly_min = 2; dly_max = 10;
        for (int i = 0; i < 4; i++) begin
            bw = wrt_cnt; bv = vld_cnt;
            s = $urandom;
            push_seq(s, 1'b1);
            bus.INT = 1'b1;
            wait_wrt(bw + 1, 40, "rand_first_rd");
            bus.INT = 1'b0;
            wait_vld(bv + 1, 200, "rand_vld");
            repeat ($urandom_range(8, 2)) @(negedge clk);
        end

        // INT pulse while in RD_PH is not queued
        dly_min = 4; dly_max = 10;
        bw = wrt_cnt; bv = vld_cnt;
        push_seq($urandom, 1'b1);
        bus.INT = 1'b1;
        wait_wrt(bw + 1, 40, "rdph_first_rd");
        bus.INT = 1'b0;
        wait_wrt(bw + 2, 40, "rdph_second_rd");
        bus.INT = 1'b1; repeat (2) @(negedge clk); bus.INT = 1'b0;
        wait_vld(bv + 1, 200, "rdph_vld");
        repeat (40) @(negedge clk);
        chk("rdph_no_extra_wrt", wrt_cnt, bw + 4);
        chk("rdph_one_vld", vld_cnt, bv + 1);

        // back-to-back with INT held
        dly_min = 2; dly_max = 8;
        bw = wrt_cnt; bv = vld_cnt;
        for (int i = 0; i < 3; i++) push_seq($urandom, 1'b1);
        bus.INT = 1'b1;
        wait_wrt(bw + 9, 400, "b2b_third_seq");
        bus.INT = 1'b0;
        wait_vld(bv + 3, 200, "b2b_vld");
        repeat (30) @(negedge clk);
        chk("b2b_wrt_count", wrt_cnt, bw + 12);
        chk("b2b_vld_count", vld_cnt, bv + 3);

        // reset while in RD_AL
        dly_min = 6; dly_max = 10;
        bw = wrt_cnt;
        samples.push_back($urandom);
        exp_cmd.push_back(16'hA200); exp_cmd.push_back(16'hA300); exp_cmd.push_back(16'hAC00);
        bus.INT = 1'b1;
        wait_wrt(bw + 1, 40, "abort_first_rd");
        bus.INT = 1'b0;
        wait_wrt(bw + 3, 100, "abort_third_rd");
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wrt",  {31'd0, bus.wrt}, 32'd0);
        chk("abort_vld",  {31'd0, bus.vld}, 32'd0);
        chk("abort_cmd",  {16'd0, bus.cmd}, 32'd0);
        chk("abort_ptch", {16'd0, bus.ptch_rt}, 32'd0);
        chk("abort_az",   {16'd0, bus.AZ}, 32'd0);
        push_cfg();
        rst = 1'b0;
        measure_wrt(lat, 3);
        chk("repwr_latency", lat, 32'd16);
        wait_wrt(bw + 7, 200, "recfg_writes");
        repeat (15) @(negedge clk);
        chk("recfg_wrt_count", wrt_cnt, bw + 7);

        // normal operation after re-configuration
        bv = vld_cnt;
        push_seq($urandom, 1'b1);
        bus.INT = 1'b1;
        measure_wrt(lat, 0);
        chk("int_latency_2", lat, 32'd3);
        @(negedge clk); bus.INT = 1'b0;
        wait_vld(bv + 1, 200, "post_reset_vld");
        repeat (10) @(negedge clk);

        chk("cmd_queue_empty",  exp_cmd.size(), 32'd0);
        chk("data_queue_empty", exp_data.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
